// File: rtl/display_scan_controller_if.sv
`default_nettype none
// ============================================================================
// display_scan_controller_if : load/ack handshake and 7-segment drive bundle
// Rev 1.0
// ============================================================================
interface display_scan_controller_if;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        load;
  logic        load_ack;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output value_in, dp_in, digit_en, load,
    input  load_ack, pending, an, seg, dp
  );

  modport slave (
    input  value_in, dp_in, digit_en, load,
    output load_ack, pending, an, seg, dp
  );
endinterface
`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
// display_scan_controller : 4-digit common-anode 7-seg scanner with blanking
// and frame-aligned shadow loading. Rev 1.0
// ============================================================================
module display_scan_controller #(
  parameter int TICK_COUNT   = 262144,
  parameter int BLANK_CYCLES = 1024
) (
  input  wire logic                 clock_100Mhz,
  input  wire logic                 reset,
  display_scan_controller_if.slave  io
);

  localparam int CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [CW-1:0] c_LAST  = CW'(TICK_COUNT - 1);
  localparam logic [CW-1:0] c_BLANK = CW'(BLANK_CYCLES);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam state_t c_ST_INIT = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

  logic [CW-1:0] r_slot_cnt;
  logic [CW-1:0] w_slot_next;
  logic [1:0]    r_digit_idx;
  logic          w_wrap;
  logic          w_frame;

  state_t r_state;
  state_t w_state_next;

  logic [15:0] r_sh_val;
  logic [3:0]  r_sh_dp;
  logic [3:0]  r_sh_en;
  logic        r_pending;
  logic [15:0] r_disp_val;
  logic [3:0]  r_disp_dp;
  logic [3:0]  r_disp_en;
  logic        r_load_ack;

  logic [3:0]  w_nib;
  logic [3:0]  w_an;
  logic [6:0]  w_seg;
  logic        w_dp;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  function automatic logic [6:0] f_hex7(input logic [3:0] n);
    case (n)
      4'h0: f_hex7 = 7'b1000000;
      4'h1: f_hex7 = 7'b1111001;
      4'h2: f_hex7 = 7'b0100100;
      4'h3: f_hex7 = 7'b0110000;
      4'h4: f_hex7 = 7'b0011001;
      4'h5: f_hex7 = 7'b0010010;
      4'h6: f_hex7 = 7'b0000010;
      4'h7: f_hex7 = 7'b1111000;
      4'h8: f_hex7 = 7'b0000000;
      4'h9: f_hex7 = 7'b0010000;
      4'hA: f_hex7 = 7'b0001000;
      4'hB: f_hex7 = 7'b0000011;
      4'hC: f_hex7 = 7'b1000110;
      4'hD: f_hex7 = 7'b0100001;
      4'hE: f_hex7 = 7'b0000110;
      default: f_hex7 = 7'b0001110;
    endcase
  endfunction

  assign w_wrap      = (r_slot_cnt == c_LAST);
  assign w_frame     = w_wrap && (r_digit_idx == 2'd3);
  assign w_slot_next = w_wrap ? '0 : r_slot_cnt + 1'b1;

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= 2'd0;
    end else begin
      r_slot_cnt <= w_slot_next;
      if (w_wrap) begin
        r_digit_idx <= r_digit_idx + 2'd1;
      end
    end
  end

  // A load on the boundary cycle wins over applying the older shadow.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_sh_val   <= '0;
      r_sh_dp    <= '0;
      r_sh_en    <= '0;
      r_pending  <= 1'b0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
      r_disp_en  <= '0;
      r_load_ack <= 1'b0;
    end else begin
      r_load_ack <= 1'b0;
      if (io.load) begin
        r_sh_val  <= io.value_in;
        r_sh_dp   <= io.dp_in;
        r_sh_en   <= io.digit_en;
        r_pending <= 1'b1;
      end else if (w_frame && r_pending) begin
        r_disp_val <= r_sh_val;
        r_disp_dp  <= r_sh_dp;
        r_disp_en  <= r_sh_en;
        r_pending  <= 1'b0;
        r_load_ack <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_state <= c_ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // State tracks the current slot count; next state looks at the next count.
  always_comb begin
    w_state_next = r_state;
    w_an         = 4'b1111;
    w_seg        = 7'b1111111;
    w_dp         = 1'b1;
    w_nib        = r_disp_val[r_digit_idx*4 +: 4];
    case (r_state)
      ST_BLANK: begin
        if (w_slot_next >= c_BLANK) begin
          w_state_next = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (w_slot_next < c_BLANK) begin
          w_state_next = ST_BLANK;
        end
        if (r_disp_en[r_digit_idx]) begin
          w_an = ~(4'b0001 << r_digit_idx);
        end
        w_seg = f_hex7(w_nib);
        w_dp  = ~r_disp_dp[r_digit_idx];
      end
      default: begin
        w_state_next = ST_BLANK;
      end
    endcase
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign io.an       = r_an;
  assign io.seg      = r_seg;
  assign io.dp       = r_dp;
  assign io.pending  = r_pending;
  assign io.load_ack = r_load_ack;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// ============================================================================
// tb_display_scan_controller : directed checks of scan timing and handshake
// Rev 1.0
// ============================================================================
module tb_display_scan_controller;

  localparam int TICK_COUNT   = 8;
  localparam int BLANK_CYCLES = 2;

  logic clk;
  logic rst;
  int   k;
  int   acks;
  int   ack_mark;
  int   n_vec;
  int   n_miss;

  display_scan_controller_if bus ();

  display_scan_controller #(
    .TICK_COUNT   (TICK_COUNT),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_dut (
    .clock_100Mhz (clk),
    .reset        (rst),
    .io           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_dp);
    chk({tag, ".an"},  {12'd0, bus.an},  {12'd0, e_an});
    chk({tag, ".seg"}, {9'd0, bus.seg},  {9'd0, e_seg});
    chk({tag, ".dp"},  {15'd0, bus.dp},  {15'd0, e_dp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    if (bus.load_ack === 1'b1) acks++;
  endtask

  task automatic goto(input int target);
    while (k < target) tick();
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dpv);
    bus.value_in = v;
    bus.digit_en = en;
    bus.dp_in    = dpv;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_miss = 0; k = 0; acks = 0; ack_mark = 0;
    rst = 1'b1;
    bus.value_in = '0; bus.dp_in = '0; bus.digit_en = '0; bus.load = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rst_out", 4'b1111, 7'b1111111, 1'b1);
      chk("rst_pend", {15'd0, bus.pending},  16'd0);
      chk("rst_ack",  {15'd0, bus.load_ack}, 16'd0);
    end
    rst = 1'b0;
    k = 0;
    acks = 0;
    chk_out("rel_k0", 4'b1111, 7'b1111111, 1'b1);
    goto(2);
    chk_out("blank_k2", 4'b1111, 7'b1111111, 1'b1);
    goto(3);
    chk_out("drive0_dark", 4'b1111, 7'b1000000, 1'b1);

    // Load 12AF at slot 1 of digit 0
    goto(1);
    k = 3;
    ack_mark = acks;
    goto(32);
    // k now counts from the same origin; recover by restarting schedule below
    chk("f0_ack", {15'd0, bus.load_ack}, 16'd0);
    goto(33);
    load_word(16'h12AF, 4'b1111, 4'b0000);
    chk("pend_set", {15'd0, bus.pending}, 16'd1);
    goto(63);
    chk("pend_hold", {15'd0, bus.pending}, 16'd1);
    chk("no_early_ack", acks - ack_mark, 0);
    goto(64);
    chk("ack_pulse", {15'd0, bus.load_ack}, 16'd1);
    chk("pend_clr", {15'd0, bus.pending}, 16'd0);
    goto(65);
    chk("ack_one_cycle", {15'd0, bus.load_ack}, 16'd0);
    chk_out("f2_blank0", 4'b1111, 7'b1111111, 1'b1);
    goto(67);
    chk_out("f2_dig0", 4'b1110, 7'b0001110, 1'b1);
    goto(72);
    chk_out("f2_dig0_end", 4'b1110, 7'b0001110, 1'b1);
    goto(73);
    chk_out("f2_blank1", 4'b1111, 7'b1111111, 1'b1);
    goto(75);
    chk_out("f2_dig1", 4'b1101, 7'b0001000, 1'b1);
    goto(83);
    chk_out("f2_dig2", 4'b1011, 7'b0100100, 1'b1);
    goto(91);
    chk_out("f2_dig3", 4'b0111, 7'b1111001, 1'b1);
    chk("single_ack", acks - ack_mark, 1);

    // Two loads before one boundary
    ack_mark = acks;
    goto(98);
    load_word(16'h0001, 4'b1111, 4'b0000);
    goto(102);
    load_word(16'h0008, 4'b1111, 4'b0000);
    goto(128);
    chk("dbl_ack", {15'd0, bus.load_ack}, 16'd1);
    goto(131);
    chk_out("dbl_dig0", 4'b1110, 7'b0000000, 1'b1);
    chk("dbl_ack_cnt", acks - ack_mark, 1);

    // Load on the boundary cycle with data pending
    goto(132);
    load_word(16'h000C, 4'b1111, 4'b0000);
    goto(159);
    ack_mark = acks;
    load_word(16'h000D, 4'b1111, 4'b0000);
    chk("bnd_no_ack", {15'd0, bus.load_ack}, 16'd0);
    chk("bnd_pend", {15'd0, bus.pending}, 16'd1);
    goto(163);
    chk_out("bnd_old", 4'b1110, 7'b0000000, 1'b1);
    goto(192);
    chk("bnd_ack", {15'd0, bus.load_ack}, 16'd1);
    chk("bnd_pend_clr", {15'd0, bus.pending}, 16'd0);
    goto(195);
    chk_out("bnd_new", 4'b1110, 7'b0100001, 1'b1);
    chk("bnd_ack_cnt", acks - ack_mark, 1);

    // Digit enables and decimal points
    goto(196);
    load_word(16'h5678, 4'b0101, 4'b0001);
    goto(227);
    chk_out("en_dig0", 4'b1110, 7'b0000000, 1'b0);
    goto(235);
    chk_out("en_dig1", 4'b1111, 7'b1111000, 1'b1);
    goto(243);
    chk_out("en_dig2", 4'b1011, 7'b0000010, 1'b1);
    goto(251);
    chk_out("en_dig3", 4'b1111, 7'b0010010, 1'b1);

    // Reset while pending, mid digit 2
    goto(258);
    load_word(16'hFFFF, 4'b1111, 4'b1111);
    goto(274);
    chk("pre_rst_pend", {15'd0, bus.pending}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    k = 0;
    ack_mark = acks;
    chk("mid_rst_pend", {15'd0, bus.pending}, 16'd0);
    chk("mid_rst_ack", {15'd0, bus.load_ack}, 16'd0);
    chk_out("mid_rst_out", 4'b1111, 7'b1111111, 1'b1);
    goto(2);
    chk_out("rs_blank", 4'b1111, 7'b1111111, 1'b1);
    goto(3);
    chk_out("rs_drive", 4'b1111, 7'b1000000, 1'b1);
    goto(5);
    load_word(16'h0009, 4'b0001, 4'b0000);
    goto(31);
    chk("rs_no_ack", acks - ack_mark, 0);
    goto(32);
    chk("rs_ack", {15'd0, bus.load_ack}, 16'd1);
    goto(35);
    chk_out("rs_dig0", 4'b1110, 7'b0010000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Time-multiplexes a 16-bit hex value onto the board's 4-digit common-anode 7-segment display. Has its own slot counter that sets the per-digit scan rate, so a separate divided clock is not used for scanning. Inserts a blanking interval before each digit to suppress ghosting. Latches new values through a load/ack handshake and applies them only at frame boundaries, so a frame never mixes old and new data.

Parameters:
TICK_COUNT, 262144, 100 MHz cycles per digit slot (about 380 Hz per digit); legal range 4 to 2^20.
BLANK_CYCLES, 1024, cycles at the start of each slot with all anodes off; must be less than TICK_COUNT.

Ports:
clock_100Mhz  input  1  board clock; all logic runs on the rising edge.
reset  input  1  synchronous, active-high.
value_in  input  16  hex value to show; nibble k drives digit k (digit 0 is rightmost).
dp_in  input  4  decimal-point request per digit, active-high.
digit_en  input  4  per-digit enable, active-high; a disabled digit stays dark.
load  input  1  single-cycle request to capture value_in, dp_in and digit_en into the shadow registers.
load_ack  output  1  one-cycle pulse when the shadow contents become the displayed contents.
pending  output  1  high while the shadow holds data that is not yet displayed.
an  output  4  anode drives, active-low.
seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low; seg[0] = a.
dp  output  1  decimal-point cathode, active-low.

Behaviour:
- Reset (synchronous, dominates everything): slot_cnt = 0, digit_idx = 0.
- Reset: display and shadow registers = 0, pending = 0, load_ack = 0.
- Reset: an = 4'b1111, seg = 7'b1111111, dp = 1.
- Slot counter: slot_cnt counts 0 to TICK_COUNT-1 and wraps. On wrap, digit_idx advances 0→1→2→3→0 (modulo 4).
- Frame boundary: the wrap cycle where digit_idx goes from 3 to 0.
- Scan FSM, BLANK state: active while slot_cnt < BLANK_CYCLES. Outputs an = 1111, seg = all 1s, dp = 1.
- Scan FSM, DRIVE state: active while slot_cnt >= BLANK_CYCLES.
  - an has only bit digit_idx low, and only if display digit_en[digit_idx] = 1; otherwise an = 1111.
  - seg = hex decode of the display nibble; dp = ~display dp[digit_idx].
- All display outputs are registered, one cycle behind slot_cnt and digit_idx.
- Hex decode (active-low), digits 0–7: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
- Hex decode (active-low), digits 8–F: 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Handshake, load = 1: shadow registers capture the inputs and pending is set on the next edge.
- Handshake, repeated loads while pending: each overwrites the shadow; the newest data wins and no ack is issued for overwritten data.
- Handshake, frame boundary with pending = 1 and load = 0: display registers take the shadow, pending clears, and load_ack = 1 for exactly the next cycle.
- Handshake, load on the frame boundary cycle: the new data goes to the shadow and pending stays 1. The previous shadow is not applied; the new data is applied at the following boundary with one ack.
- No pending data at a boundary: no change and no ack.
- Reset mid-frame or mid-pending: pending data is discarded, no ack is issued, and scanning restarts at digit 0, slot_cnt 0.
- No combinational path from load to an, seg or dp.

Test Plan:
1. Reset held for 3 cycles (TICK_COUNT=8, BLANK_CYCLES=2) → an=1111, seg=1111111, dp=1, pending=0, load_ack=0 throughout; all counters 0 after release.
2. load with value_in=16'h12AF, digit_en=1111, dp_in=0000 at slot 1 of digit 0 → pending=1 until the frame boundary. Next frame shows, per slot, 2 blank cycles then the digit:
   - digit 0: an=1110, seg=0001110 (F)
   - digit 1: an=1101, seg=0001000 (A)
   - digit 2: an=1011, seg=0100100 (2)
   - digit 3: an=0111, seg=1111001 (1)
   - load_ack: a single 1-cycle pulse at the boundary.
3. Two loads (16'h0001, then 16'h0008) before one boundary → one ack only; digit 0 shows seg=0000000 (8).
4. load asserted exactly on the boundary cycle with pending set → no ack at that boundary, pending stays 1; data applied with one ack one frame (32 cycles) later.
5. digit_en=0101, dp_in=0001 → digits 1 and 3 keep an=1111 in DRIVE; digit 0 drives dp=0; digit 2 drives dp=1.
6. reset pulse while pending=1 mid-digit 2 → pending=0, display=0, no ack; scan restarts at digit 0 after 2 blank cycles.
